div_operand_sequencer: RTL



---
 rtl/div_pkg.sv | 29 ++
 rtl/div_settle_timer.sv | 28 ++
 rtl/div_operand_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider operand sequencer: state encoding,
// settle-counter width and the special-operand detectors.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } div_state_t;

    localparam int DIV_CNT_W = 8;

    // Operands are passed zero-extended to 64 bits; n selects the live width.
    function automatic logic [63:0] width_mask(input int unsigned n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic is_div_zero(input logic [63:0] divisor, input int unsigned n);
        return (divisor & width_mask(n)) == 64'd0;
    endfunction

    function automatic logic is_div_overflow(input logic [63:0] dividend,
                                             input logic [63:0] divisor,
                                             input int unsigned n);
        return ((dividend & width_mask(n)) == (64'd1 << (n - 1))) &&
               ((divisor & width_mask(n)) == width_mask(n));
    endfunction

endpackage

// File: rtl/div_settle_timer.sv
// 8-bit down-counter timing the divider settle window; tc is high when the
// count has reached zero.
module div_settle_timer
    import div_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DIV_CNT_W-1:0] load_value,
    input  logic                 enable,
    output logic                 tc
);

    logic [DIV_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/div_operand_sequencer.sv
// Registers operands onto the combinational array divider, waits a settle
// window, then holds the quotient until consumed. DIV_SPECIAL_CASE_EN enables
// the divide-by-zero and MIN/-1 bypass.
//
// state  | meaning
// IDLE   | waiting for an operand pair, In_Ready high
// SETTLE | operands held on the array, timer counting down
// DONE   | quotient presented, waiting for Out_Ready
module div_operand_sequencer
    import div_pkg::*;
#(
    parameter int N       = 32,
    parameter int LATENCY = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         In_Valid,
    output logic         In_Ready,
    input  logic [N-1:0] In_Dividend,
    input  logic [N-1:0] In_Divisor,
    output logic [N-1:0] Div_Dividend,
    output logic [N-1:0] Div_Divisor,
    input  logic [N-1:0] Div_Quotient,
    output logic         Out_Valid,
    input  logic         Out_Ready,
    output logic [N-1:0] Out_Quotient,
    output logic         Out_DivZero,
    output logic         Out_Overflow
);

    localparam logic [DIV_CNT_W-1:0] SETTLE_LOAD = DIV_CNT_W'(LATENCY - 1);

    div_state_t state, state_next;

    logic         accept;
    logic         capture;
    logic         timer_load;
    logic         timer_en;
    logic         timer_tc;
    logic         pair_zero;
    logic         pair_ovf;
    logic [N-1:0] div_dividend_q;
    logic [N-1:0] div_divisor_q;
    logic [N-1:0] out_quotient_q;
    logic         out_div_zero_q;
    logic         out_overflow_q;

`ifdef DIV_SPECIAL_CASE_EN
    assign pair_zero = is_div_zero(64'(In_Divisor), N);
    assign pair_ovf  = !pair_zero && is_div_overflow(64'(In_Dividend), 64'(In_Divisor), N);
`else
    assign pair_zero = 1'b0;
    assign pair_ovf  = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state)
            IDLE: begin
                if (In_Valid && !Reset) begin
                    accept = 1'b1;
                    if (pair_zero || pair_ovf) begin
                        state_next = DONE;
                    end else begin
                        timer_load = 1'b1;
                        state_next = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (timer_tc) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            DONE: begin
                if (Out_Ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    div_settle_timer u_settle_timer (
        .clk        (Clk),
        .reset      (Reset),
        .load       (timer_load),
        .load_value (SETTLE_LOAD),
        .enable     (timer_en),
        .tc         (timer_tc)
    );

    // Div_Quotient is only trusted on the final settle edge (capture).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            out_quotient_q <= '0;
            out_div_zero_q <= 1'b0;
            out_overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                div_dividend_q <= In_Dividend;
                div_divisor_q  <= In_Divisor;
                out_div_zero_q <= pair_zero;
                out_overflow_q <= pair_ovf;
                if (pair_zero) begin
                    out_quotient_q <= '1;
                end else if (pair_ovf) begin
                    out_quotient_q <= {1'b1, {(N-1){1'b0}}};
                end
            end
            if (capture) begin
                out_quotient_q <= Div_Quotient;
            end
        end
    end

    assign In_Ready     = (state == IDLE) && !Reset;
    assign Out_Valid    = (state == DONE);
    assign Div_Dividend = div_dividend_q;
    assign Div_Divisor  = div_divisor_q;
    assign Out_Quotient = out_quotient_q;
    assign Out_DivZero  = out_div_zero_q;
    assign Out_Overflow = out_overflow_q;

endmodule
